// File: rtl/instruction_cache_ctrl.sv
// Direct-mapped, read-only instruction cache controller.
//
// Eight lines of one 16-byte block each. A fetch address splits into
// word offset PC[3:2], line index PC[6:4] and tag PC[9:7]; the other PC bits
// are ignored. Hits answer in the same cycle. A miss stalls the PC register,
// reads the whole block from instruction memory, installs it, and then
// resumes.
//
// Ports
//   CLK           single clock, all state changes on posedge
//   RESET         synchronous, active-high
//   PC            byte address of the instruction to fetch
//   INSTRUCTION   fetched word; holds the last hit value while stalled
//   BUSYWAIT      stall request to the PC register (high = hold PC)
//   MEM_READ      block read request to instruction memory
//   MEM_ADDRESS   block address PC[9:4] latched when the miss was seen
//   MEM_READDATA  16-byte block, word 0 at [31:0], word 3 at [127:96]
//   MEM_BUSYWAIT  memory busy; low while MEM_READ is high = data valid
module instruction_cache_ctrl #(
  parameter int NBLOCKS = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NBLOCKS-1:0] valid_q;
  logic [2:0]         tag_q  [NBLOCKS];
  logic [127:0]       data_q [NBLOCKS];

  logic [5:0]  addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        fill_we;

  logic [1:0]  pc_off;
  logic [2:0]  pc_idx;
  logic [2:0]  pc_tag;
  logic        hit;
  logic [31:0] hit_word;
  logic [127:0] sel_block;

  // Address bits outside the 1 KiB window are deliberately ignored, which
  // makes higher addresses alias onto the same lines.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

  assign pc_off    = PC[3:2];
  assign pc_idx    = PC[6:4];
  assign pc_tag    = PC[9:7];
  assign sel_block = data_q[pc_idx];
  assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  always_comb begin
    hit_word = sel_block[31:0];
    case (pc_off)
      2'd0: hit_word = sel_block[31:0];
      2'd1: hit_word = sel_block[63:32];
      2'd2: hit_word = sel_block[95:64];
      2'd3: hit_word = sel_block[127:96];
      default: hit_word = sel_block[31:0];
    endcase
  end

  assign MEM_ADDRESS = addr_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    fill_we     = 1'b0;
    BUSYWAIT    = 1'b1;
    MEM_READ    = 1'b0;
    INSTRUCTION = instr_q;

    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          // Hit word goes straight out and is also captured so it can be
          // held during a later stall.
          BUSYWAIT    = 1'b0;
          INSTRUCTION = hit_word;
          instr_d     = hit_word;
        end else begin
          addr_d  = PC[9:4];
          state_d = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill_we = 1'b1;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset must never stall the PC, must drop the memory request at once,
    // and must win over a fill completing on the same edge.
    if (RESET) begin
      BUSYWAIT    = 1'b0;
      MEM_READ    = 1'b0;
      INSTRUCTION = instr_q;
      fill_we     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      addr_q  <= 6'd0;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      if (fill_we) begin
        valid_q[addr_q[2:0]] <= 1'b1;
      end
    end
  end

  // Line index and tag of a fill come from the latched block address, so a
  // PC that wanders during the stall cannot redirect the write.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      data_q[addr_q[2:0]] <= MEM_READDATA;
      tag_q[addr_q[2:0]]  <= addr_q[5:3];
    end
  end

endmodule

// File: tb/tb_instruction_cache_ctrl.sv
module tb_instruction_cache_ctrl;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [31:0]  PC = 32'h0;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA = '0;
  logic         MEM_BUSYWAIT = 1'b1;

  instruction_cache_ctrl #(.NBLOCKS(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory ----------------
  // mem_lat = number of cycles MEM_READ stays high; data arrives in the last.
  int mem_lat = 5;
  int mem_cnt = 0;
  int gen     = 0;

  function automatic logic [127:0] block_of(input logic [5:0] a, input int g);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = {8'(g), 2'b00, a, 16'(w + 1)};
    return b;
  endfunction

  task automatic mem_drive();
    if (MEM_READ) begin
      if (mem_cnt + 1 >= mem_lat) begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = block_of(MEM_ADDRESS, gen);
        gen++;
      end else begin
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
      end
      mem_cnt++;
    end else begin
      mem_cnt      = 0;
      MEM_BUSYWAIT = 1'($urandom_range(0, 1));
      MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    mem_drive();
  endtask

  // ---------------- behavioural cache model ----------------
  logic [7:0]   m_valid = '0;
  logic [2:0]   m_tag  [8];
  logic [127:0] m_data [8];
  logic [5:0]   m_addr  = '0;
  logic [31:0]  m_instr = '0;
  int           m_phase = 0;   // 0 serving fetches, 1 waiting on memory, 2 block just installed
  bit           model_on = 1'b0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_tag[i]  = '0;
      m_data[i] = '0;
    end
  end

  function automatic logic m_hit(input logic [31:0] a);
    return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[9:7]);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    return m_data[a[6:4]][a[3:2]*32 +: 32];
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      m_valid  = '0;
      m_addr   = '0;
      m_instr  = '0;
      m_phase  = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (m_phase == 0) begin
        if (m_hit(PC)) m_instr = m_word(PC);
        else begin
          m_addr  = PC[9:4];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!MEM_BUSYWAIT) begin
          m_valid[m_addr[2:0]] = 1'b1;
          m_tag[m_addr[2:0]]   = m_addr[5:3];
          m_data[m_addr[2:0]]  = MEM_READDATA;
          m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  logic        e_bw, e_mr;
  logic [31:0] e_in;

  always @(negedge CLK) begin
    if (model_on) begin
      e_in = m_instr;
      e_mr = 1'b0;
      e_bw = 1'b1;
      if (RESET) begin
        e_bw = 1'b0;
      end else if (m_phase == 0) begin
        if (m_hit(PC)) begin
          e_bw = 1'b0;
          e_in = m_word(PC);
        end
      end else if (m_phase == 1) begin
        e_mr = 1'b1;
      end
      chk("m_busywait", 32'(BUSYWAIT), 32'(e_bw));
      chk("m_mem_read", 32'(MEM_READ), 32'(e_mr));
      chk("m_mem_addr", 32'(MEM_ADDRESS), 32'(m_addr));
      chk("m_instr", INSTRUCTION, e_in);
    end
  end

  // ---------------- directed + random stimulus ----------------
  // Caller has just done tick() and set PC; counts stalled cycles until a hit.
  task automatic miss_wait(output int n, input logic [5:0] ea, input bit scramble);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) return;
      n++;
      if (MEM_READ) chk("maddr_hold", 32'(MEM_ADDRESS), 32'(ea));
      tick();
      if (scramble) PC = MEM_READ ? $urandom : {22'h0, ea, 4'h0};
    end
    total++;
    bad++;
    $display("FAIL miss_timeout: BUSYWAIT still %b after 60 cycles, required 0", BUSYWAIT);
  endtask

  task automatic fetch_hit(input string nm, input logic [31:0] a, input logic [31:0] exp);
    tick();
    PC = a;
    @(negedge CLK);
    chk({nm, "_instr"}, INSTRUCTION, exp);
    chk({nm, "_bw"}, 32'(BUSYWAIT), 32'd0);
    chk({nm, "_mread"}, 32'(MEM_READ), 32'd0);
  endtask

  int n;
  logic [31:0] pc;

  initial begin
    // reset state
    RESET = 1'b1;
    PC = 32'h0;
    mem_lat = 5;
    tick();
    tick();
    @(negedge CLK);
    chk("rst_instr", INSTRUCTION, 32'h0);
    chk("rst_maddr", 32'(MEM_ADDRESS), 32'd0);
    chk("rst_bw", 32'(BUSYWAIT), 32'd0);
    chk("rst_mread", 32'(MEM_READ), 32'd0);
    gen = 0;

    // cold miss: 1 miss cycle + 5 read cycles + 1 install cycle
    tick();
    RESET = 1'b0;
    PC = 32'h0;
    miss_wait(n, 6'h00, 1'b0);
    chk("cold_penalty", 32'(n), 32'd7);
    chk("cold_instr", INSTRUCTION, 32'h0000_0001);

    // spatial hits in the same block
    fetch_hit("sp4", 32'h4, 32'h0000_0002);
    fetch_hit("sp8", 32'h8, 32'h0000_0003);
    fetch_hit("sp12", 32'hC, 32'h0000_0004);

    // conflict on index 0 with tag 1
    tick();
    PC = 32'h80;
    miss_wait(n, 6'h08, 1'b0);
    chk("conf_penalty", 32'(n), 32'd7);
    chk("conf_instr", INSTRUCTION, 32'h0108_0001);
    tick();
    PC = 32'h0;
    miss_wait(n, 6'h00, 1'b0);
    chk("remiss_penalty", 32'(n), 32'd7);
    chk("remiss_instr", INSTRUCTION, 32'h0200_0001);

    // high-address aliasing
    fetch_hit("alias", 32'h400, 32'h0200_0001);

    // PC wanders during the stall; fill must land on the latched block
    mem_lat = 3;
    tick();
    PC = 32'h1F0;
    miss_wait(n, 6'h1F, 1'b1);
    chk("stall_penalty", 32'(n), 32'd5);
    chk("stall_instr", INSTRUCTION, 32'h031F_0001);
    fetch_hit("stall_w3", 32'h1FC, 32'h031F_0004);

    // reset in the 2nd read cycle while memory delivers
    mem_lat = 2;
    tick();
    PC = 32'h40;
    @(negedge CLK);
    chk("abort_miss", 32'(BUSYWAIT), 32'd1);
    tick();
    @(negedge CLK);
    chk("abort_rd1", 32'(MEM_READ), 32'd1);
    tick();
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_mread", 32'(MEM_READ), 32'd0);
    chk("abort_bw", 32'(BUSYWAIT), 32'd0);
    tick();
    RESET = 1'b0;
    mem_lat = 5;
    PC = 32'h40;
    #1;
    chk("abort_after40", 32'(BUSYWAIT), 32'd1);
    PC = 32'h0;
    miss_wait(n, 6'h00, 1'b0);
    chk("abort_pc0_penalty", 32'(n), 32'd7);
    chk("abort_pc0_instr", INSTRUCTION, 32'h0500_0001);

    // randomized traffic against the model
    pc = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      RESET = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 3) begin
        pc = $urandom;
        pc[9:7] = 3'($urandom_range(0, 1));
        PC = pc;
      end
      if (!MEM_READ) mem_lat = $urandom_range(1, 6);
    end
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
